serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial binary subtractor. It computes a − b − bin over WIDTH clock cycles using one full-subtractor cell and a registered borrow, processing operands LSB first. It sits beside the combinational adder blocks in the arithmetic library as their inverse operation. It is the area-cheap alternative when a parallel WIDTH-bit subtractor is not warranted.

## Interface
Parameters:
- WIDTH, default 8: operand and result width; legal range ≥ 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new subtraction; honoured only in IDLE.
- a  in  WIDTH  minuend; sampled on the accepted start edge.
- b  in  WIDTH  subtrahend; sampled on the accepted start edge.
- bin  in  1  borrow-in; sampled on the accepted start edge.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; diff and bout are valid from this cycle on.
- diff  out  WIDTH  result register; holds the last completed result.
- bout  out  1  final borrow-out; holds the last completed value.
- d_bit  out  1  serial difference bit produced in the previous SHIFT cycle.
- d_valid  out  1  qualifies d_bit.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on start = 1.
  - SHIFT → DONE after WIDTH shift cycles.
  - DONE → IDLE unconditionally.
- Accepted start:
  - Load shift registers sa ← a and sb ← b.
  - Borrow flop brw ← bin; bit counter ← 0.
  - The internal result shift register is not cleared.
- Each SHIFT cycle, with x = sa[0], y = sb[0]:
  - d = x ^ y ^ brw
  - brw ← (~x & y) | (~(x ^ y) & brw)
  - sa and sb shift right one bit.
  - d enters the internal result shift register at the MSB, shifting right.
  - counter increments.
  - d_bit ← d and d_valid ← 1; both are registered.
- On SHIFT → DONE: diff ← internal result register; bout ← brw (the final borrow).
- Arithmetic contract:
  - {bout, diff} = ({1'b0,a} − {1'b0,b} − bin) mod 2^(WIDTH+1).
  - bout = 1 exactly when a < b + bin (unsigned).
- diff and bout change only on the SHIFT → DONE transition (and on reset). They are stable throughout busy and IDLE.
- start in SHIFT or DONE is ignored: no reload, no effect on the current operation.
- Counter width is clog2(WIDTH+1). WIDTH = 1 must work: exactly one SHIFT cycle.

## Timing
- Let edge E0 be the clock edge where start is accepted.
- SHIFT occupies edges E1..E_WIDTH. d_valid = 1 during the WIDTH cycles following edges E1..E_WIDTH. d_bit in cycle k carries bit k−1 of the result.
- State enters DONE after edge E_WIDTH. done = 1 and the new diff/bout are visible for the single cycle following E_WIDTH.
- busy rises after E0 and falls after E_WIDTH+1.
- Latency from start edge to done: WIDTH cycles. Earliest next accepted start is edge E_WIDTH+2.
- Reset:
  - state = IDLE, busy = 0, done = 0, diff = 0, bout = 0, d_bit = 0, d_valid = 0.
  - Internal shift registers, brw and counter are cleared.
- rst has priority over start in the same cycle.
- Reset mid-operation aborts the operation. No done pulse is produced, and diff/bout return to 0.

## Test plan
- WIDTH=8; a=0x5A, b=0x3C, bin=0 → done exactly 8 cycles after the start edge; diff=0x1E, bout=0; d_bit sequence LSB-first 0,1,1,1,1,0,0,0.
- WIDTH=8; a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0x80, b=0x80, bin=1 → diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=1 → diff=0xFE, bout=0.
- Start held high continuously with changing a/b → only IDLE-cycle starts accepted; one done per WIDTH+2 cycles; diff unchanged while busy.
- Assert rst at cycle 4 of SHIFT → next cycle: all outputs 0, busy=0, and no done pulse. A fresh start then completes normally.
- WIDTH=1 instance, all 8 combinations of a, b, bin → results match the contract; done 1 cycle after start.
- 1000 random WIDTH=16 operations against the arithmetic contract → zero mismatches; done pulse width is always 1.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor. It computes a - b - bin over WIDTH clock cycles,
//   LSB first, using one full-subtractor cell and a registered borrow.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (aborts any operation)
//   start    in   request a new subtraction; honoured only while idle
//   a, b     in   minuend / subtrahend, sampled on the accepted start edge
//   bin      in   borrow-in, sampled on the accepted start edge
//   busy     out  high while an operation is shifting or completing
//   done     out  one-cycle pulse; diff/bout are valid from this cycle on
//   diff     out  last completed difference (held)
//   bout     out  last completed borrow-out (held)
//   d_bit    out  difference bit produced in the previous shift cycle
//   d_valid  out  qualifies d_bit
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             d_bit,
  output logic             d_valid
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
  logic             brw_q, bout_q, busy_q, done_q, dbit_q, dvld_q;
  logic [CW-1:0]    cnt_q;

  logic             dif_d, brw_d;
  logic [WIDTH-1:0] res_d;

  // Full-subtractor cell on the current LSBs; the new difference bit is
  // pushed in at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
  always_comb begin
    dif_d = sa_q[0] ^ sb_q[0] ^ brw_q;
    brw_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
    res_d = res_q >> 1;
    res_d[WIDTH-1] = dif_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbit_q  <= 1'b0;
      dvld_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          dvld_q <= 1'b0;
          if (start) begin
            // The result shift register is deliberately left as is; every
            // bit of it is overwritten during the WIDTH shift cycles.
            sa_q    <= a;
            sb_q    <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sa_q   <= sa_q >> 1;
          sb_q   <= sb_q >> 1;
          brw_q  <= brw_d;
          res_q  <= res_d;
          cnt_q  <= cnt_q + CW'(1);
          dbit_q <= dif_d;
          dvld_q <= 1'b1;
          if (cnt_q == LAST) begin
            // Publish the full result including the bit produced this cycle.
            diff_q  <= res_d;
            bout_q  <= brw_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          dvld_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          dvld_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign diff    = diff_q;
  assign bout    = bout_q;
  assign d_bit   = dbit_q;
  assign d_valid = dvld_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (WIDTH 8, 1 and 16) share one
// clock and reset. A timing/arithmetic model predicts every output each cycle;
// directed operations add hand-computed literal expectations.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st[3];
  logic [15:0] av[3], bv[3];
  logic        bi[3];

  logic        bsy[3], dn[3], bo[3], dbt[3], dv[3];
  logic [15:0] df[3];
  logic [7:0]  df8;
  logic [0:0]  df1;
  logic [15:0] df16;

  assign df[0] = {8'h00, df8};
  assign df[1] = {15'h0000, df1};
  assign df[2] = df16;

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
    .bin(bi[0]), .busy(bsy[0]), .done(dn[0]), .diff(df8), .bout(bo[0]),
    .d_bit(dbt[0]), .d_valid(dv[0]));

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(st[1]), .a(av[1][0:0]), .b(bv[1][0:0]),
    .bin(bi[1]), .busy(bsy[1]), .done(dn[1]), .diff(df1), .bout(bo[1]),
    .d_bit(dbt[1]), .d_valid(dv[1]));

  serial_subtractor #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(st[2]), .a(av[2]), .b(bv[2]),
    .bin(bi[2]), .busy(bsy[2]), .done(dn[2]), .diff(df16), .bout(bo[2]),
    .d_bit(dbt[2]), .d_valid(dv[2]));

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  function automatic int wd(int i);
    return (i == 0) ? 8 : (i == 1) ? 1 : 16;
  endfunction

  task automatic chk(string nm, int i, logic [16:0] act, logic [16:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s w%0d: got %0h expected %0h at %0t", nm, wd(i), act, exp, $time);
    end
  endtask

  // Model: k = edges elapsed since the accepted start edge (-1 when idle).
  // The whole result is known at acceptance from plain arithmetic; the timing
  // rules then say which parts of it are visible after each edge.
  int          k[3];
  logic [16:0] er[3];
  logic [15:0] ediff[3];
  logic        ebout[3], ebusy[3], edone[3], edv[3], edbit[3];

  initial begin
    logic [15:0] m;
    for (int i = 0; i < 3; i++) begin
      k[i] = -1; er[i] = '0; ediff[i] = '0; ebout[i] = 1'b0;
      ebusy[i] = 1'b0; edone[i] = 1'b0; edv[i] = 1'b0; edbit[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        m = 16'((17'd1 << wd(i)) - 17'd1);
        if (rst) begin
          k[i] = -1; ediff[i] = '0; ebout[i] = 1'b0; ebusy[i] = 1'b0;
          edone[i] = 1'b0; edv[i] = 1'b0; edbit[i] = 1'b0;
        end else if (k[i] < 0) begin
          if (st[i]) begin
            er[i] = ({1'b0, av[i] & m} - {1'b0, bv[i] & m} - 17'(bi[i]))
                    & ((17'd1 << (wd(i) + 1)) - 17'd1);
            k[i] = 0;
            ebusy[i] = 1'b1;
          end
        end else begin
          k[i]++;
          if (k[i] <= wd(i)) begin
            edv[i] = 1'b1;
            edbit[i] = er[i][k[i]-1];
          end
          if (k[i] == wd(i)) begin
            edone[i] = 1'b1;
            ediff[i] = er[i][15:0] & m;
            ebout[i] = er[i][wd(i)];
          end
          if (k[i] == wd(i) + 1) begin
            edone[i] = 1'b0; ebusy[i] = 1'b0; edv[i] = 1'b0; k[i] = -1;
          end
        end
      end
    end
  end

  // Per-cycle comparison, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 3; i++) begin
          chk("busy", i, 17'(bsy[i]), 17'(ebusy[i]));
          chk("done", i, 17'(dn[i]), 17'(edone[i]));
          chk("d_valid", i, 17'(dv[i]), 17'(edv[i]));
          chk("diff", i, 17'(df[i]), 17'(ediff[i]));
          chk("bout", i, 17'(bo[i]), 17'(ebout[i]));
          if (edv[i]) chk("d_bit", i, 17'(dbt[i]), 17'(edbit[i]));
        end
      end
    end
  end

  // One operation: returns edges from accept to done and the serial bits.
  task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic c, output int lat, output logic [15:0] bits);
    int nb;
    nb = 0;
    bits = '0;
    @(negedge clk);
    st[i] = 1'b1; av[i] = a; bv[i] = b; bi[i] = c;
    @(negedge clk);
    st[i] = 1'b0;
    lat = 0;
    forever begin
      if (dv[i] && nb < 16) begin
        bits[nb] = dbt[i];
        nb++;
      end
      if (dn[i] || lat > 40) break;
      @(negedge clk);
      lat++;
    end
    if (!dn[i]) chk("done_timeout", i, 17'd0, 17'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int          lat, nd;
  logic [15:0] bits, ra, rb;
  logic        rc;
  logic [16:0] ex;
  logic [1:0]  w1tbl[8];

  initial begin
    w1tbl = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3};
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; av[i] = '0; bv[i] = '0; bi[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, 17'(bsy[i]), 17'd0);
      chk("rst_done", i, 17'(dn[i]), 17'd0);
      chk("rst_diff", i, 17'(df[i]), 17'd0);
      chk("rst_bout", i, 17'(bo[i]), 17'd0);
      chk("rst_dvalid", i, 17'(dv[i]), 17'd0);
      chk("rst_dbit", i, 17'(dbt[i]), 17'd0);
    end
    rst = 1'b0;

    // WIDTH 8 directed vectors
    run_op(0, 16'h005A, 16'h003C, 1'b0, lat, bits);
    chk("lat_5A_3C", 0, 17'(lat), 17'd8);
    chk("dbits_5A_3C", 0, 17'(bits), 17'h0001E);
    chk("diff_5A_3C", 0, 17'(df[0]), 17'h0001E);
    chk("bout_5A_3C", 0, 17'(bo[0]), 17'd0);

    run_op(0, 16'h0000, 16'h0001, 1'b0, lat, bits);
    chk("diff_00_01", 0, 17'(df[0]), 17'h000FF);
    chk("bout_00_01", 0, 17'(bo[0]), 17'd1);

    run_op(0, 16'h0080, 16'h0080, 1'b1, lat, bits);
    chk("diff_80_80_1", 0, 17'(df[0]), 17'h000FF);
    chk("bout_80_80_1", 0, 17'(bo[0]), 17'd1);

    run_op(0, 16'h00FF, 16'h0000, 1'b1, lat, bits);
    chk("diff_FF_00_1", 0, 17'(df[0]), 17'h000FE);
    chk("bout_FF_00_1", 0, 17'(bo[0]), 17'd0);

    // start held high: only idle-cycle starts are taken, one done per 10 cycles
    @(negedge clk);
    st[0] = 1'b1; av[0] = 16'($urandom); bv[0] = 16'($urandom); bi[0] = 1'($urandom);
    nd = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (dn[0]) nd++;
      av[0] = 16'($urandom); bv[0] = 16'($urandom); bi[0] = 1'($urandom);
    end
    st[0] = 1'b0;
    chk("held_start_dones", 0, 17'(nd), 17'd4);
    repeat (12) @(negedge clk);

    // reset in the 4th shift cycle aborts the operation
    @(negedge clk);
    st[0] = 1'b1; av[0] = 16'h00A5; bv[0] = 16'h0017; bi[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 0, 17'(bsy[0]), 17'd0);
    chk("abort_done", 0, 17'(dn[0]), 17'd0);
    chk("abort_diff", 0, 17'(df[0]), 17'd0);
    chk("abort_bout", 0, 17'(bo[0]), 17'd0);
    chk("abort_dvalid", 0, 17'(dv[0]), 17'd0);
    chk("abort_dbit", 0, 17'(dbt[0]), 17'd0);
    rst = 1'b0;
    nd = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (dn[0]) nd++;
    end
    chk("abort_no_done", 0, 17'(nd), 17'd0);
    run_op(0, 16'h00C3, 16'h0045, 1'b1, lat, bits);
    chk("lat_after_abort", 0, 17'(lat), 17'd8);
    chk("diff_C3_45_1", 0, 17'(df[0]), 17'h0007D);
    chk("bout_C3_45_1", 0, 17'(bo[0]), 17'd0);

    // WIDTH 1: all eight input combinations
    for (int idx = 0; idx < 8; idx++) begin
      run_op(1, 16'((idx >> 2) & 1), 16'((idx >> 1) & 1), 1'(idx & 1), lat, bits);
      chk("w1_lat", 1, 17'(lat), 17'd1);
      chk("w1_result", 1, 17'({bo[1], df[1][0]}), 17'(w1tbl[idx]));
    end

    // WIDTH 16: random operations against the arithmetic contract
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (n == 0) begin ra = 16'h0000; rb = 16'hFFFF; rc = 1'b1; end
      if (n == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b0; end
      ex = {1'b0, ra} - {1'b0, rb} - 17'(rc);
      run_op(2, ra, rb, rc, lat, bits);
      chk("w16_lat", 2, 17'(lat), 17'd16);
      chk("w16_result", 2, {bo[2], df[2]}, ex);
      chk("w16_dbits", 2, 17'(bits), 17'(ex[15:0]));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
